// File: rtl/rx_tx_pkg.sv
// Shared definitions for the rx_tx link: default data width, tx state
// encodings and the widths of the internal counters.
package rx_tx_pkg;

  localparam int DATA_W = 32;
  localparam int CNT_W  = 32;
  localparam int GAP_W  = 16;
  localparam int PER_W  = 16;

  typedef logic [1:0] tx_state_t;

  localparam tx_state_t IDLE = 2'd0;
  localparam tx_state_t SEND = 2'd1;
  localparam tx_state_t GAP  = 2'd2;

endpackage

// File: rtl/rx_tx_rx.sv
// Receiver: throttles ready once every RX_PERIOD cycles, captures accepted
// words and flags any break in the incrementing sequence.
module rx
  import rx_tx_pkg::*;
#(
  parameter int DATA_W    = rx_tx_pkg::DATA_W,
  parameter int RX_PERIOD = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] data,
  input  logic              valid,
  output logic              ready,
  output logic [DATA_W-1:0] data_show,
  output logic [CNT_W-1:0]  rcv_cnt,
  output logic              err
);

  logic [PER_W-1:0]  per_cnt;
  logic [PER_W-1:0]  per_nxt;
  logic [DATA_W-1:0] expected;

  always_comb begin
    per_nxt = '0;
    if (RX_PERIOD > 1 && per_cnt != PER_W'(RX_PERIOD - 1))
      per_nxt = per_cnt + PER_W'(1);
  end

  // ready is decided from the next counter value so the register lines up
  // with the cycle in which the counter sits at RX_PERIOD-1
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      per_cnt <= '0;
      ready   <= 1'b0;
    end else begin
      per_cnt <= per_nxt;
      ready   <= (RX_PERIOD <= 1) || (per_nxt != PER_W'(RX_PERIOD - 1));
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_show <= '0;
      rcv_cnt   <= '0;
      err       <= 1'b0;
      expected  <= '0;
    end else if (valid && ready) begin
      data_show <= data;
      rcv_cnt   <= rcv_cnt + CNT_W'(1);
      if (data != expected)
        err <= 1'b1;
      expected  <= data + DATA_W'(1);
    end
  end

endmodule

// File: rtl/rx_tx_tx.sv
// Transmitter: emits an incrementing word sequence over a valid/ready link,
// optionally idling TX_GAP cycles after every accepted word.
module tx
  import rx_tx_pkg::*;
#(
  parameter int DATA_W = rx_tx_pkg::DATA_W,
  parameter int TX_GAP = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ready,
  output logic [DATA_W-1:0] data,
  output logic              valid
);

  tx_state_t        state;
  logic [GAP_W-1:0] gap_cnt;

  // valid is raised one cycle after entering SEND from IDLE, then stays
  // registered so it never depends on ready within a cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      data    <= '0;
      valid   <= 1'b0;
      gap_cnt <= '0;
    end else begin
      case (state)
        IDLE: state <= SEND;
        SEND: begin
          if (!valid) begin
            valid <= 1'b1;
          end else if (ready) begin
            data <= data + DATA_W'(1);
            if (TX_GAP != 0) begin
              state   <= GAP;
              valid   <= 1'b0;
              gap_cnt <= '0;
            end
          end
        end
        GAP: begin
          if (gap_cnt == GAP_W'(TX_GAP - 1)) begin
            state <= SEND;
            valid <= 1'b1;
          end else begin
            gap_cnt <= gap_cnt + GAP_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: rtl/rx_tx.sv
// Top level: point-to-point wiring of the tx and rx blocks; the link signals
// are exposed for observation.
module rx_tx
  import rx_tx_pkg::*;
#(
  parameter int DATA_W    = rx_tx_pkg::DATA_W,
  parameter int TX_GAP    = 0,
  parameter int RX_PERIOD = 0
) (
  input  logic              clk,
  input  logic              rst,
  output logic [DATA_W-1:0] link_data,
  output logic              link_valid,
  output logic              link_ready,
  output logic [DATA_W-1:0] data_show,
  output logic [CNT_W-1:0]  rcv_cnt,
  output logic              err
);

  tx #(.DATA_W(DATA_W), .TX_GAP(TX_GAP)) u_tx (
    .clk   (clk),
    .rst   (rst),
    .ready (link_ready),
    .data  (link_data),
    .valid (link_valid)
  );

  rx #(.DATA_W(DATA_W), .RX_PERIOD(RX_PERIOD)) u_rx (
    .clk       (clk),
    .rst       (rst),
    .data      (link_data),
    .valid     (link_valid),
    .ready     (link_ready),
    .data_show (data_show),
    .rcv_cnt   (rcv_cnt),
    .err       (err)
  );

endmodule

// File: tb/tb_rx_tx.sv
// Directed bench for rx_tx: several parameterisations share one clock/reset,
// plus a standalone rx driven directly for sequence-error injection.
module tb_rx_tx;

  logic clk;
  logic rst;

  logic [31:0] a_data, a_show, a_cnt;
  logic        a_valid, a_ready, a_err;
  logic [31:0] b_data, b_show, b_cnt;
  logic        b_valid, b_ready, b_err;
  logic [31:0] c_data, c_show, c_cnt;
  logic        c_valid, c_ready, c_err;
  logic [3:0]  d_data, d_show;
  logic [31:0] d_cnt;
  logic        d_valid, d_ready, d_err;
  logic [31:0] s_data, s_show, s_cnt;
  logic        s_valid, s_ready, s_err;

  int vectors;
  int miscompares;

  rx_tx #(.DATA_W(32), .TX_GAP(0), .RX_PERIOD(0)) dut_a (
    .clk(clk), .rst(rst), .link_data(a_data), .link_valid(a_valid), .link_ready(a_ready),
    .data_show(a_show), .rcv_cnt(a_cnt), .err(a_err));

  rx_tx #(.DATA_W(32), .TX_GAP(2), .RX_PERIOD(0)) dut_b (
    .clk(clk), .rst(rst), .link_data(b_data), .link_valid(b_valid), .link_ready(b_ready),
    .data_show(b_show), .rcv_cnt(b_cnt), .err(b_err));

  rx_tx #(.DATA_W(32), .TX_GAP(0), .RX_PERIOD(4)) dut_c (
    .clk(clk), .rst(rst), .link_data(c_data), .link_valid(c_valid), .link_ready(c_ready),
    .data_show(c_show), .rcv_cnt(c_cnt), .err(c_err));

  rx_tx #(.DATA_W(4), .TX_GAP(0), .RX_PERIOD(0)) dut_d (
    .clk(clk), .rst(rst), .link_data(d_data), .link_valid(d_valid), .link_ready(d_ready),
    .data_show(d_show), .rcv_cnt(d_cnt), .err(d_err));

  rx #(.DATA_W(32), .RX_PERIOD(0)) dut_s (
    .clk(clk), .rst(rst), .data(s_data), .valid(s_valid), .ready(s_ready),
    .data_show(s_show), .rcv_cnt(s_cnt), .err(s_err));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic restart();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    #1;
    vectors++;
    if ({a_data, a_valid, a_ready, a_show, a_cnt, a_err} !== '0) begin
      miscompares++;
      $display("[TB] FAIL reset_a: got data=%h v=%b r=%b show=%h cnt=%0d err=%b, want all 0",
               a_data, a_valid, a_ready, a_show, a_cnt, a_err);
    end
    vectors++;
    if ({b_valid, b_ready, c_valid, c_ready, d_valid, s_ready, s_err} !== '0) begin
      miscompares++;
      $display("[TB] FAIL reset_others: got bv=%b br=%b cv=%b cr=%b dv=%b sr=%b se=%b, want 0",
               b_valid, b_ready, c_valid, c_ready, d_valid, s_ready, s_err);
    end
  endtask

  task automatic test_back_to_back();
    restart();
    step();
    step();
    vectors++;
    if ({a_valid, a_ready, a_data} !== {1'b1, 1'b1, 32'd0}) begin
      miscompares++;
      $display("[TB] FAIL b2b_edge1: got v=%b r=%b data=%h, want 1 1 0", a_valid, a_ready, a_data);
    end
    step();
    vectors++;
    if ({a_show, a_cnt} !== {32'd0, 32'd1}) begin
      miscompares++;
      $display("[TB] FAIL b2b_edge2: got show=%h cnt=%0d, want 0 1", a_show, a_cnt);
    end
    repeat (8) step();
    vectors++;
    if ({a_show, a_cnt, a_err, a_data} !== {32'd8, 32'd9, 1'b0, 32'd9}) begin
      miscompares++;
      $display("[TB] FAIL b2b_edge10: got show=%h cnt=%0d err=%b data=%h, want 8 9 0 9",
               a_show, a_cnt, a_err, a_data);
    end
  endtask

  task automatic test_gap();
    int exp_cnt;
    restart();
    for (int e = 0; e <= 10; e++) begin
      step();
      if (e >= 1) begin
        vectors++;
        if (b_valid !== ((e - 1) % 3 == 0)) begin
          miscompares++;
          $display("[TB] FAIL gap_valid e=%0d: got %b, want %b", e, b_valid, ((e - 1) % 3 == 0));
        end
      end
      exp_cnt = (e >= 2) ? (e - 2) / 3 + 1 : 0;
      vectors++;
      if (b_cnt !== exp_cnt || (exp_cnt > 0 && b_show !== exp_cnt - 1)) begin
        miscompares++;
        $display("[TB] FAIL gap_data e=%0d: got cnt=%0d show=%h, want cnt=%0d show=%0d",
                 e, b_cnt, b_show, exp_cnt, exp_cnt - 1);
      end
    end
    vectors++;
    if (b_err !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL gap_err: got %b, want 0", b_err);
    end
  endtask

  task automatic test_ready_period();
    int          exp_cnt;
    logic [31:0] prev_data;
    logic        prev_valid, prev_ready;
    exp_cnt = 0;
    restart();
    for (int e = 0; e < 100; e++) begin
      prev_data  = c_data;
      prev_valid = c_valid;
      prev_ready = c_ready;
      step();
      if (e >= 2 && e % 4 != 3) exp_cnt++;
      vectors++;
      if (c_ready !== ((e + 1) % 4 != 3)) begin
        miscompares++;
        $display("[TB] FAIL period_ready e=%0d: got %b, want %b", e, c_ready, ((e + 1) % 4 != 3));
      end
      if (prev_valid && !prev_ready) begin
        vectors++;
        if (c_data !== prev_data) begin
          miscompares++;
          $display("[TB] FAIL period_hold e=%0d: got %h, want %h", e, c_data, prev_data);
        end
      end
      if (exp_cnt > 0) begin
        vectors++;
        if (c_show !== exp_cnt - 1) begin
          miscompares++;
          $display("[TB] FAIL period_show e=%0d: got %h, want %0d", e, c_show, exp_cnt - 1);
        end
      end
    end
    vectors++;
    if ({c_cnt, c_err} !== {32'd73, 1'b0}) begin
      miscompares++;
      $display("[TB] FAIL period_total: got cnt=%0d err=%b, want 73 0", c_cnt, c_err);
    end
  endtask

  task automatic test_wrap();
    restart();
    for (int e = 0; e < 20; e++) begin
      step();
      if (e == 17 || e == 18 || e == 19) begin
        vectors++;
        if (d_show !== 4'((e - 2) % 16)) begin
          miscompares++;
          $display("[TB] FAIL wrap_show e=%0d: got %h, want %h", e, d_show, 4'((e - 2) % 16));
        end
      end
    end
    vectors++;
    if ({d_cnt, d_err} !== {32'd18, 1'b0}) begin
      miscompares++;
      $display("[TB] FAIL wrap_total: got cnt=%0d err=%b, want 18 0", d_cnt, d_err);
    end
  endtask

  task automatic test_error();
    logic [31:0] words [5];
    logic        errs  [5];
    words = '{32'd0, 32'd1, 32'd2, 32'd5, 32'd6};
    errs  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    s_valid = 1'b0;
    s_data  = '0;
    restart();
    step();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      s_valid = 1'b1;
      s_data  = words[i];
      step();
      vectors++;
      if ({s_show, s_err} !== {words[i], errs[i]}) begin
        miscompares++;
        $display("[TB] FAIL error_word%0d: got show=%h err=%b, want %h %b",
                 i, s_show, s_err, words[i], errs[i]);
      end
    end
    @(negedge clk);
    s_valid = 1'b0;
    s_data  = 32'd99;
    repeat (3) step();
    vectors++;
    if ({s_err, s_cnt, s_show} !== {1'b1, 32'd5, 32'd6}) begin
      miscompares++;
      $display("[TB] FAIL error_sticky: got err=%b cnt=%0d show=%h, want 1 5 6", s_err, s_cnt, s_show);
    end
  endtask

  task automatic test_reset_mid();
    restart();
    repeat (6) step();
    #2;
    rst = 1'b1;
    #1;
    vectors++;
    if ({a_data, a_valid, a_ready, a_show, a_cnt, a_err} !== '0) begin
      miscompares++;
      $display("[TB] FAIL midrst_async: got data=%h v=%b r=%b show=%h cnt=%0d, want 0",
               a_data, a_valid, a_ready, a_show, a_cnt);
    end
    for (int i = 0; i < 3; i++) begin
      step();
      vectors++;
      if ({a_data, a_valid, a_ready, a_show, a_cnt, a_err} !== '0) begin
        miscompares++;
        $display("[TB] FAIL midrst_hold%0d: got data=%h v=%b show=%h cnt=%0d, want 0",
                 i, a_data, a_valid, a_show, a_cnt);
      end
    end
    @(negedge clk);
    rst = 1'b0;
    repeat (3) step();
    vectors++;
    if ({a_show, a_cnt, a_err, a_data} !== {32'd0, 32'd1, 1'b0, 32'd1}) begin
      miscompares++;
      $display("[TB] FAIL midrst_restart: got show=%h cnt=%0d err=%b data=%h, want 0 1 0 1",
               a_show, a_cnt, a_err, a_data);
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst         = 1'b1;
    s_valid     = 1'b0;
    s_data      = '0;
    test_reset();
    test_back_to_back();
    test_gap();
    test_ready_period();
    test_wrap();
    test_error();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/rx_tx.md
RX_TX -- requirements
Module: rx_tx

Interface
REQ-001 Parameter: DATA_W, 32, link and display data width.
REQ-002 Parameter: TX_GAP, 0, idle cycles tx inserts after each accepted word; 0 means back-to-back.
REQ-003 Parameter: RX_PERIOD, 0, rx deasserts ready one cycle in every RX_PERIOD cycles; 0 means always ready.
REQ-004 One clock; reset is asynchronous and active-high.
REQ-005 clk  input  1  rising-edge clock for all state.
REQ-006 rst  input  1  asynchronous, active-high reset.
REQ-007 link_data  output  DATA_W  tx→rx data bus.
REQ-008 link_valid  output  1  tx valid.
REQ-009 link_ready  output  1  rx ready.
REQ-010 data_show  output  DATA_W  last word accepted by rx.
REQ-011 rcv_cnt  output  32  number of accepted words, wraps modulo 2^32.
REQ-012 err  output  1  sticky sequence-error flag.

Function
REQ-013 Handshake: a transfer occurs on a rising edge where link_valid=1 and link_ready=1; no other condition transfers data.
REQ-014 tx data, valid and ready are all registered; valid never depends combinationally on ready, and ready never depends combinationally on valid.
REQ-015 tx state machine:
- IDLE → SEND on the first edge after reset release.
- SEND holds link_valid=1, with link_data stable, until the handshake.
- On the handshake: link_data increments by 1 (wrapping 2^DATA_W-1 → 0); next state is SEND if TX_GAP=0, else GAP.
- GAP drives link_valid=0 for exactly TX_GAP cycles, then returns to SEND.
REQ-016 rx ready generation:
- rx keeps a free-running cycle counter modulo RX_PERIOD.
- link_ready=0 in the cycle where the counter equals RX_PERIOD-1; link_ready=1 otherwise.
- With RX_PERIOD=0 or 1, link_ready=1 permanently after the first post-reset edge.
REQ-017 On each handshake, rx:
- loads data_show with link_data;
- increments rcv_cnt;
- compares link_data with its expected value (reset 0), sets err=1 on mismatch, and then loads expected with link_data+1 (wrapping).
REQ-018 err, once set, stays set until reset.
REQ-019 When no handshake occurs, data_show, rcv_cnt and expected hold their values.
REQ-020 Latency: data_show reflects a word on the edge that transfers it, i.e. 0 cycles after the handshake edge.

Reset
REQ-021 While rst=1:
- link_data=0, link_valid=0, link_ready=0;
- data_show=0, rcv_cnt=0, err=0;
- expected=0, all counters=0;
- tx state=IDLE.
REQ-022 Asserting rst mid-transfer aborts the transfer immediately; after release the sequence restarts from 0 with no error flagged.

Structure
REQ-023 A shared package holds DATA_W, the tx state enum (IDLE, SEND, GAP) and the counter widths.
REQ-024 rx_tx instantiates two sub-modules connected point-to-point:
- tx: data, valid, ready in;
- rx: data, valid in, ready, data_show, rcv_cnt, err.
REQ-025 The top level contains no logic beyond wiring.

Verification
REQ-026 TX_GAP=0, RX_PERIOD=0, release rst before edge 0 → edge 1: link_valid=1, link_ready=1, link_data=0; edge 2: data_show=0, rcv_cnt=1; edge 10: data_show=8, rcv_cnt=9, err=0.
REQ-027 TX_GAP=2, RX_PERIOD=0 → link_valid pattern 1,0,0 repeating; data_show steps 0,1,2 every 3 cycles; err=0.
REQ-028 TX_GAP=0, RX_PERIOD=4 → link_ready low 1 cycle in 4; link_data held while valid=1 and ready=0; 100 cycles produce rcv_cnt≈75 with contiguous data_show values; err=0.
REQ-029 Force link_data to 0x5 during one handshake where 0x3 is expected → err=1 on that edge and stays 1.
REQ-030 Preload tx data to 0xFFFF_FFFF with expected matched → next transfers 0xFFFF_FFFF then 0x0000_0000; err=0.
REQ-031 Assert rst for 3 cycles mid-stream → all outputs 0 during rst; after release the first accepted word is 0 and err=0.
